// File: rtl/ocx_tlx_framer_cmd_arb_if.sv
// Bus bundle between the TLX framer command arbiter and its surroundings:
// the two FIFO heads, credit returns, firmware controls and the output stage.
interface ocx_tlx_framer_cmd_arb_if #(
   parameter int unsigned DATA_WIDTH   = 172,
   parameter int unsigned CREDIT_WIDTH = 6,
   parameter int unsigned RET_WIDTH    = 4
);
   logic [DATA_WIDTH-1:0]   cmd_data_in;
   logic                    cmd_data_available;
   logic                    cmd_rd_done;
   logic [DATA_WIDTH-1:0]   rsp_data_in;
   logic                    rsp_data_available;
   logic                    rsp_rd_done;
   logic [RET_WIDTH-1:0]    cmd_credit_return;
   logic [RET_WIDTH-1:0]    rsp_credit_return;
   logic                    credit_load;
   logic [CREDIT_WIDTH-1:0] cmd_credit_init;
   logic [CREDIT_WIDTH-1:0] rsp_credit_init;
   logic                    halt_req;
   logic                    halted;
   logic                    out_valid;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_src;
   logic                    out_ready;
   logic [CREDIT_WIDTH-1:0] cmd_credit_count;
   logic [CREDIT_WIDTH-1:0] rsp_credit_count;
   logic                    credit_error;

   // Arbiter side
   modport slave (
      input  cmd_data_in, cmd_data_available, rsp_data_in, rsp_data_available,
      input  cmd_credit_return, rsp_credit_return, credit_load,
      input  cmd_credit_init, rsp_credit_init, halt_req, out_ready,
      output cmd_rd_done, rsp_rd_done, halted, out_valid, out_data, out_src,
      output cmd_credit_count, rsp_credit_count, credit_error
   );

   // FIFO / framer / firmware side
   modport master (
      output cmd_data_in, cmd_data_available, rsp_data_in, rsp_data_available,
      output cmd_credit_return, rsp_credit_return, credit_load,
      output cmd_credit_init, rsp_credit_init, halt_req, out_ready,
      input  cmd_rd_done, rsp_rd_done, halted, out_valid, out_data, out_src,
      input  cmd_credit_count, rsp_credit_count, credit_error
   );
endinterface

// File: rtl/ocx_tlx_framer_cmd_arb.sv
// TLX framer command-slot arbiter: round-robin between the cmd and rsp FIFOs,
// gated by per-source TL credits, feeding a one-deep valid/ready output stage.
// A halt/drain mode lets firmware quiesce the path and load initial credits.
module ocx_tlx_framer_cmd_arb #(
   parameter int unsigned DATA_WIDTH   = 172,
   parameter int unsigned CREDIT_WIDTH = 6,
   parameter int unsigned RET_WIDTH    = 4
) (
   input logic                    clock,
   input logic                    reset,
   ocx_tlx_framer_cmd_arb_if.slave bus
);

   localparam int unsigned SUM_W = CREDIT_WIDTH + 1;

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_HALT_PEND = 2'd1;
   localparam logic [1:0] ST_HALTED    = 2'd2;

   localparam logic SRC_CMD = 1'b0;
   localparam logic SRC_RSP = 1'b1;

   logic [1:0]              state_q, state_d;
   logic                    last_grant_q;
   logic                    out_valid_q;
   logic                    out_src_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [CREDIT_WIDTH-1:0] cmd_credit_q, cmd_credit_d;
   logic [CREDIT_WIDTH-1:0] rsp_credit_q, rsp_credit_d;
   logic                    credit_error_q, credit_error_d;

   logic                    run;
   logic                    slot_open;
   logic                    cmd_eligible, rsp_eligible;
   logic                    grant_cmd, grant_rsp, grant;
   logic                    load_ok;
   logic [SUM_W-1:0]        cmd_sum, rsp_sum;

   // cur - take + ret at one extra bit; take never underflows since a grant
   // needs a non-zero count.
   function automatic logic [SUM_W-1:0] credit_next(input logic [CREDIT_WIDTH-1:0] cur,
                                                    input logic                    take,
                                                    input logic [RET_WIDTH-1:0]    ret);
      return {1'b0, cur} - SUM_W'(take) + SUM_W'(ret);
   endfunction

   assign run          = (state_q == ST_RUN);
   assign cmd_eligible = bus.cmd_data_available & (cmd_credit_q != '0) & run;
   assign rsp_eligible = bus.rsp_data_available & (rsp_credit_q != '0) & run;
   assign slot_open    = !out_valid_q | bus.out_ready;

   // On a tie the source that did not win last time gets the slot.
   assign grant_cmd = !reset & slot_open & cmd_eligible &
                      (!rsp_eligible | (last_grant_q == SRC_RSP));
   assign grant_rsp = !reset & slot_open & rsp_eligible &
                      (!cmd_eligible | (last_grant_q == SRC_CMD));
   assign grant     = grant_cmd | grant_rsp;
   assign load_ok   = bus.credit_load & (state_q == ST_HALTED);

   // Halt/drain state machine next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (bus.halt_req) state_d = ST_HALT_PEND;
         end
         ST_HALT_PEND: begin
            if (!bus.halt_req)                       state_d = ST_RUN;
            else if (!out_valid_q || bus.out_ready)  state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (!bus.halt_req) state_d = ST_RUN;
         end
         default: state_d = ST_HALTED;
      endcase
   end

   // Credit counters next value with saturation and sticky error
   always_comb begin
      cmd_sum        = credit_next(cmd_credit_q, grant_cmd, bus.cmd_credit_return);
      rsp_sum        = credit_next(rsp_credit_q, grant_rsp, bus.rsp_credit_return);
      cmd_credit_d   = cmd_sum[SUM_W-1] ? '1 : cmd_sum[CREDIT_WIDTH-1:0];
      rsp_credit_d   = rsp_sum[SUM_W-1] ? '1 : rsp_sum[CREDIT_WIDTH-1:0];
      credit_error_d = credit_error_q | cmd_sum[SUM_W-1] | rsp_sum[SUM_W-1];
      if (load_ok) begin
         // Returns arriving in the load cycle are dropped.
         cmd_credit_d   = bus.cmd_credit_init;
         rsp_credit_d   = bus.rsp_credit_init;
         credit_error_d = credit_error_q;
      end
   end

   // State, credits, round-robin pointer and output stage registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_HALTED;
         last_grant_q   <= SRC_RSP;
         out_valid_q    <= 1'b0;
         out_src_q      <= 1'b0;
         out_data_q     <= '0;
         cmd_credit_q   <= '0;
         rsp_credit_q   <= '0;
         credit_error_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_credit_q   <= cmd_credit_d;
         rsp_credit_q   <= rsp_credit_d;
         credit_error_q <= credit_error_d;
         if (grant) begin
            last_grant_q <= grant_rsp;
            out_src_q    <= grant_rsp;
            out_data_q   <= grant_rsp ? bus.rsp_data_in : bus.cmd_data_in;
            out_valid_q  <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
         end
      end
   end

   assign bus.cmd_rd_done      = grant_cmd;
   assign bus.rsp_rd_done      = grant_rsp;
   assign bus.halted           = (state_q == ST_HALTED);
   assign bus.out_valid        = out_valid_q;
   assign bus.out_data         = out_data_q;
   assign bus.out_src          = out_src_q;
   assign bus.cmd_credit_count = cmd_credit_q;
   assign bus.rsp_credit_count = rsp_credit_q;
   assign bus.credit_error     = credit_error_q;

endmodule

// File: tb/tb_ocx_tlx_framer_cmd_arb.sv
// Self-checking bench for ocx_tlx_framer_cmd_arb: FIFO models feed the heads,
// a scoreboard queue predicts each output-stage entry, a vector table covers
// the credit arithmetic, and hand sequences cover the multi-cycle corners.
module tb_ocx_tlx_framer_cmd_arb;

   localparam int unsigned DW = 172;
   localparam int unsigned CW = 6;
   localparam int unsigned RW = 4;

   typedef logic [DW-1:0] data_t;
   typedef struct {
      logic  src;
      data_t data;
   } sb_t;
   typedef struct {
      int ci, ri, cr, rr, ec, er;
      bit ee;
   } row_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ocx_tlx_framer_cmd_arb_if #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .RET_WIDTH(RW)) bus ();

   ocx_tlx_framer_cmd_arb #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .RET_WIDTH(RW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int    errors = 0;
   int    checks = 0;
   data_t cmd_q[$];
   data_t rsp_q[$];
   sb_t   sb_q[$];
   bit    grant_log[$];
   int    seq = 0;

   task automatic check(input string name, input data_t act, input data_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic data_t mk_data(input logic src);
      logic [191:0] r;
      data_t d;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d = r[DW-1:0];
      d[15:0] = 16'(seq);
      d[DW-1] = src;
      seq++;
      return d;
   endfunction

   task automatic refresh();
      bus.cmd_data_available = (cmd_q.size() != 0);
      bus.cmd_data_in        = (cmd_q.size() != 0) ? cmd_q[0] : '0;
      bus.rsp_data_available = (rsp_q.size() != 0);
      bus.rsp_data_in        = (rsp_q.size() != 0) ? rsp_q[0] : '0;
   endtask

   task automatic push_fifo(input int ncmd, input int nrsp);
      for (int i = 0; i < ncmd; i++) cmd_q.push_back(mk_data(1'b0));
      for (int i = 0; i < nrsp; i++) rsp_q.push_back(mk_data(1'b1));
      refresh();
   endtask

   // One clock: sample at negedge, update FIFO models and scoreboard after posedge.
   task automatic step();
      logic s_cmd, s_rsp, s_pop;
      sb_t  e;
      @(negedge clock);
      s_cmd = bus.cmd_rd_done;
      s_rsp = bus.rsp_rd_done;
      s_pop = bus.out_valid & bus.out_ready;
      if (s_cmd) begin
         check("cmd_rd_avail", data_t'(bus.cmd_data_available), data_t'(1));
         check("cmd_rd_not_halted", data_t'(bus.halted), data_t'(0));
      end
      if (s_rsp) begin
         check("rsp_rd_avail", data_t'(bus.rsp_data_available), data_t'(1));
         check("rsp_rd_not_halted", data_t'(bus.halted), data_t'(0));
      end
      if (s_cmd && s_rsp) check("single_grant", data_t'(2), data_t'(1));
      if (s_pop) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", data_t'(1), data_t'(0));
         end else begin
            e = sb_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_src", data_t'(bus.out_src), data_t'(e.src));
         end
      end
      @(posedge clock);
      #1;
      if (s_cmd && cmd_q.size() != 0) begin
         sb_q.push_back('{src: 1'b0, data: cmd_q.pop_front()});
         grant_log.push_back(1'b0);
      end
      if (s_rsp && rsp_q.size() != 0) begin
         sb_q.push_back('{src: 1'b1, data: rsp_q.pop_front()});
         grant_log.push_back(1'b1);
      end
      refresh();
   endtask

   task automatic do_reset();
      reset                 = 1'b1;
      bus.halt_req          = 1'b1;
      bus.out_ready         = 1'b0;
      bus.credit_load       = 1'b0;
      bus.cmd_credit_return = '0;
      bus.rsp_credit_return = '0;
      bus.cmd_credit_init   = '0;
      bus.rsp_credit_init   = '0;
      cmd_q.delete();
      rsp_q.delete();
      refresh();
      step();
      step();
      reset = 1'b0;
      sb_q.delete();
      grant_log.delete();
   endtask

   task automatic load(input int c, input int r, input int cr, input int rr);
      bus.credit_load       = 1'b1;
      bus.cmd_credit_init   = CW'(c);
      bus.rsp_credit_init   = CW'(r);
      bus.cmd_credit_return = RW'(cr);
      bus.rsp_credit_return = RW'(rr);
      step();
      bus.credit_load       = 1'b0;
      bus.cmd_credit_return = '0;
      bus.rsp_credit_return = '0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 30 && sb_q.size() != 0; i++) step();
      check("sb_drained", data_t'(sb_q.size()), data_t'(0));
   endtask

   row_t  rows[5];
   data_t d0;
   logic  s0;

   initial begin
      rows[0] = '{ci: 5,  ri: 3,  cr: 2,  rr: 1,  ec: 7,  er: 4,  ee: 1'b0};
      rows[1] = '{ci: 0,  ri: 63, cr: 0,  rr: 0,  ec: 0,  er: 63, ee: 1'b0};
      rows[2] = '{ci: 62, ri: 10, cr: 3,  rr: 0,  ec: 63, er: 10, ee: 1'b1};
      rows[3] = '{ci: 60, ri: 50, cr: 15, rr: 15, ec: 63, er: 63, ee: 1'b1};
      rows[4] = '{ci: 48, ri: 0,  cr: 15, rr: 15, ec: 63, er: 15, ee: 1'b0};

      // Reset state
      do_reset();
      check("rst_halted", data_t'(bus.halted), data_t'(1));
      check("rst_out_valid", data_t'(bus.out_valid), data_t'(0));
      check("rst_out_data", bus.out_data, data_t'(0));
      check("rst_out_src", data_t'(bus.out_src), data_t'(0));
      check("rst_cmd_cred", data_t'(bus.cmd_credit_count), data_t'(0));
      check("rst_rsp_cred", data_t'(bus.rsp_credit_count), data_t'(0));
      check("rst_cred_err", data_t'(bus.credit_error), data_t'(0));

      // Credit arithmetic vectors, exercised in HALTED (no grants)
      for (int i = 0; i < 5; i++) begin
         do_reset();
         load(rows[i].ci, rows[i].ri, 7, 3);
         check("load_drops_ret_cmd", data_t'(bus.cmd_credit_count), data_t'(rows[i].ci));
         check("load_drops_ret_rsp", data_t'(bus.rsp_credit_count), data_t'(rows[i].ri));
         bus.cmd_credit_return = RW'(rows[i].cr);
         bus.rsp_credit_return = RW'(rows[i].rr);
         step();
         bus.cmd_credit_return = '0;
         bus.rsp_credit_return = '0;
         check("vec_cmd_cred", data_t'(bus.cmd_credit_count), data_t'(rows[i].ec));
         check("vec_rsp_cred", data_t'(bus.rsp_credit_count), data_t'(rows[i].er));
         check("vec_cred_err", data_t'(bus.credit_error), data_t'(rows[i].ee));
      end

      // Credit gating: 2 credits, 3 entries
      do_reset();
      load(2, 0, 0, 0);
      push_fifo(3, 0);
      bus.out_ready = 1'b1;
      bus.halt_req  = 1'b0;
      step();
      check("gate_cred_2", data_t'(bus.cmd_credit_count), data_t'(2));
      step();
      check("gate_cred_1", data_t'(bus.cmd_credit_count), data_t'(1));
      step();
      check("gate_cred_0", data_t'(bus.cmd_credit_count), data_t'(0));
      step();
      check("gate_grants", data_t'(grant_log.size()), data_t'(2));
      check("gate_waiting", data_t'(cmd_q.size()), data_t'(1));
      bus.cmd_credit_return = 4'd1;
      step();
      bus.cmd_credit_return = '0;
      check("gate_no_early", data_t'(grant_log.size()), data_t'(2));
      step();
      check("gate_third", data_t'(grant_log.size()), data_t'(3));
      check("gate_cred_end", data_t'(bus.cmd_credit_count), data_t'(0));
      drain();

      // Round robin with both sources backlogged
      do_reset();
      load(4, 4, 0, 0);
      push_fifo(4, 4);
      bus.out_ready = 1'b1;
      bus.halt_req  = 1'b0;
      for (int i = 0; i < 10; i++) step();
      drain();
      check("rr_count", data_t'(grant_log.size()), data_t'(8));
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check("rr_order", data_t'(grant_log[i]), data_t'(i % 2));
      check("rr_cmd_cred", data_t'(bus.cmd_credit_count), data_t'(0));
      check("rr_rsp_cred", data_t'(bus.rsp_credit_count), data_t'(0));

      // Backpressure: stage held for 5 cycles
      do_reset();
      load(4, 4, 0, 0);
      push_fifo(3, 3);
      bus.out_ready = 1'b0;
      bus.halt_req  = 1'b0;
      step();
      step();
      check("bp_first", data_t'(grant_log.size()), data_t'(1));
      check("bp_valid", data_t'(bus.out_valid), data_t'(1));
      d0 = bus.out_data;
      s0 = bus.out_src;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_data_stable", bus.out_data, d0);
         check("bp_src_stable", data_t'(bus.out_src), data_t'(s0));
      end
      check("bp_no_grant", data_t'(grant_log.size()), data_t'(1));
      bus.out_ready = 1'b1;
      step();
      check("bp_regrant", data_t'(grant_log.size()), data_t'(2));
      if (grant_log.size() > 1) check("bp_regrant_src", data_t'(grant_log[1]), data_t'(1));
      drain();

      // Halt/drain and credit_load gating
      do_reset();
      load(4, 4, 0, 0);
      push_fifo(2, 0);
      bus.out_ready = 1'b0;
      bus.halt_req  = 1'b0;
      step();
      step();
      check("h_valid", data_t'(bus.out_valid), data_t'(1));
      check("h_cred", data_t'(bus.cmd_credit_count), data_t'(3));
      load(9, 9, 0, 0);
      check("h_run_load_cmd", data_t'(bus.cmd_credit_count), data_t'(3));
      check("h_run_load_rsp", data_t'(bus.rsp_credit_count), data_t'(4));
      bus.halt_req = 1'b1;
      step();
      check("h_pend_not_halted", data_t'(bus.halted), data_t'(0));
      load(9, 9, 0, 0);
      check("h_pend_load_cmd", data_t'(bus.cmd_credit_count), data_t'(3));
      check("h_pend_still", data_t'(bus.halted), data_t'(0));
      step();
      check("h_pend_no_grant", data_t'(grant_log.size()), data_t'(1));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("h_halted", data_t'(bus.halted), data_t'(1));
      check("h_empty", data_t'(bus.out_valid), data_t'(0));
      check("h_no_grant", data_t'(grant_log.size()), data_t'(1));
      load(20, 30, 0, 0);
      check("h_load_cmd", data_t'(bus.cmd_credit_count), data_t'(20));
      check("h_load_rsp", data_t'(bus.rsp_credit_count), data_t'(30));
      check("h_sb_empty", data_t'(sb_q.size()), data_t'(0));

      // Saturation: grant nets against return, no error; no grant saturates
      do_reset();
      load(62, 0, 0, 0);
      push_fifo(1, 0);
      bus.out_ready = 1'b1;
      bus.halt_req  = 1'b0;
      step();
      bus.cmd_credit_return = 4'd2;
      step();
      bus.cmd_credit_return = '0;
      check("sat_grant", data_t'(grant_log.size()), data_t'(1));
      check("sat_grant_cred", data_t'(bus.cmd_credit_count), data_t'(63));
      check("sat_grant_err", data_t'(bus.credit_error), data_t'(0));
      bus.halt_req = 1'b1;
      for (int i = 0; i < 10 && !bus.halted; i++) step();
      check("sat_halt_reached", data_t'(bus.halted), data_t'(1));
      load(62, 0, 0, 0);
      check("sat_reload", data_t'(bus.cmd_credit_count), data_t'(62));
      bus.cmd_credit_return = 4'd3;
      step();
      bus.cmd_credit_return = '0;
      check("sat_cred", data_t'(bus.cmd_credit_count), data_t'(63));
      check("sat_err", data_t'(bus.credit_error), data_t'(1));
      for (int i = 0; i < 3; i++) step();
      check("sat_err_sticky", data_t'(bus.credit_error), data_t'(1));
      drain();

      // Reset mid-operation discards the held entry
      do_reset();
      load(6, 5, 0, 0);
      push_fifo(3, 0);
      bus.out_ready = 1'b0;
      bus.halt_req  = 1'b0;
      step();
      step();
      check("mr_pre_valid", data_t'(bus.out_valid), data_t'(1));
      check("mr_pre_cred", data_t'(bus.cmd_credit_count), data_t'(5));
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clock);
      check("mr_cmd_rd", data_t'(bus.cmd_rd_done), data_t'(0));
      check("mr_rsp_rd", data_t'(bus.rsp_rd_done), data_t'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb_q.delete();
      check("mr_valid", data_t'(bus.out_valid), data_t'(0));
      check("mr_cmd_cred", data_t'(bus.cmd_credit_count), data_t'(0));
      check("mr_rsp_cred", data_t'(bus.rsp_credit_count), data_t'(0));
      check("mr_halted", data_t'(bus.halted), data_t'(1));
      check("mr_out_data", bus.out_data, data_t'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
